// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose
//   Two-master, one-slave round-robin bus arbiter. Master 0 is instruction
//   fetch and master 1 is load/store. A request is a master's wr_en or
//   rd_en. The arbiter grants one master at a time and routes that
//   master's request fields combinationally to the shared slave. It routes
//   the slave's response back to the same master. If the slave does not
//   acknowledge within TIMEOUT grant cycles, the arbiter aborts the
//   transfer.
//
// Parameters
//   TIMEOUT   maximum grant cycles without s_ack before abort (2..255)
//
// Ports
//   clock, reset_n              single clock; asynchronous active-low reset
//   mN_addr/be/wr_en/rd_en/     request fields from master N (N = 0, 1)
//     wr_data
//   mN_rd_data/busy/ack         response returned to master N
//   s_addr/be/wr_en/wr_data/    request fields driven to the slave
//     rd_en
//   s_rd_data/busy/ack          response from the slave
//   err                         one-cycle pulse on a timeout abort
//   o_dbg_state                 FSM state: 0 = IDLE, 1 = GRANT0, 2 = GRANT1
//   o_dbg_last_grant            master granted most recently
//
// Handshake
//   A master requests by raising wr_en or rd_en. It must hold all of its
//   request fields stable until it observes mN_ack = 1 for one cycle. The
//   arbiter does not register those fields. While a master is not being
//   served, it sees busy = 1, ack = 0 and rd_data = 0. While a master is
//   being served, busy and ack mirror the slave. The exception is the
//   timeout cycle: in that cycle the arbiter itself raises ack, returns
//   rd_data = 0, and withdraws rd_en/wr_en from the slave.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  // master 0 (instruction fetch)
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic        m0_wr_en,
  input  logic        m0_rd_en,
  input  logic [31:0] m0_wr_data,
  output logic [31:0] m0_rd_data,
  output logic        m0_busy,
  output logic        m0_ack,
  // master 1 (load/store)
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic        m1_wr_en,
  input  logic        m1_rd_en,
  input  logic [31:0] m1_wr_data,
  output logic [31:0] m1_rd_data,
  output logic        m1_busy,
  output logic        m1_ack,
  // shared slave
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic        s_wr_en,
  output logic [31:0] s_wr_data,
  output logic        s_rd_en,
  input  logic [31:0] s_rd_data,
  input  logic        s_busy,
  input  logic        s_ack,
  // status
  output logic        err,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_last_grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_last_grant;
  logic       w_last_grant_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;

  logic       w_req0;
  logic       w_req1;
  logic       w_in_grant;
  logic       w_timeout;
  logic       w_done;

  assign w_req0     = m0_wr_en | m0_rd_en;
  assign w_req1     = m1_wr_en | m1_rd_en;
  assign w_in_grant = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);

  // A slave ack in the last allowed cycle wins over the timeout.
  assign w_timeout  = w_in_grant && !s_ack && (r_wait_cnt == LP_TO_LAST);
  assign w_done     = s_ack | w_timeout;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_wait_cnt   <= w_wait_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, last_grant and wait counter
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_wait_cnt_next   = r_wait_cnt;

    case (r_state)
      ST_IDLE: begin
        // On a tie, grant the master that was not served most recently.
        if (w_req0 && w_req1) begin
          w_state_next = r_last_grant ? ST_GRANT0 : ST_GRANT1;
        end else if (w_req0) begin
          w_state_next = ST_GRANT0;
        end else if (w_req1) begin
          w_state_next = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        // The grant ends only on ack or timeout. A dropped request
        // does not end it.
        if (w_done) begin
          w_state_next = w_req1 ? ST_GRANT1 : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (w_done) begin
          w_state_next = w_req0 ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Grant entry: record the owner and restart the wait count. A grant
    // state never follows itself directly, so any change of state into a
    // grant state is an entry.
    if (w_state_next != r_state) begin
      w_wait_cnt_next = 8'd0;
      if (w_state_next == ST_GRANT0) begin
        w_last_grant_next = 1'b0;
      end else if (w_state_next == ST_GRANT1) begin
        w_last_grant_next = 1'b1;
      end
    end else if (w_in_grant && !s_ack && (r_wait_cnt != 8'hFF)) begin
      w_wait_cnt_next = r_wait_cnt + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Request routing to the slave and response routing to the masters
  // -------------------------------------------------------------------------
  always_comb begin
    s_addr     = 32'd0;
    s_be       = 4'd0;
    s_wr_en    = 1'b0;
    s_wr_data  = 32'd0;
    s_rd_en    = 1'b0;
    m0_rd_data = 32'd0;
    m0_busy    = 1'b1;
    m0_ack     = 1'b0;
    m1_rd_data = 32'd0;
    m1_busy    = 1'b1;
    m1_ack     = 1'b0;
    err        = 1'b0;

    case (r_state)
      ST_GRANT0: begin
        s_addr     = m0_addr;
        s_be       = m0_be;
        s_wr_data  = m0_wr_data;
        s_wr_en    = m0_wr_en & ~w_timeout;
        s_rd_en    = m0_rd_en & ~w_timeout;
        m0_rd_data = w_timeout ? 32'd0 : s_rd_data;
        m0_busy    = s_busy;
        m0_ack     = w_done;
        err        = w_timeout;
      end
      ST_GRANT1: begin
        s_addr     = m1_addr;
        s_be       = m1_be;
        s_wr_data  = m1_wr_data;
        s_wr_en    = m1_wr_en & ~w_timeout;
        s_rd_en    = m1_rd_en & ~w_timeout;
        m1_rd_data = w_timeout ? 32'd0 : s_rd_data;
        m1_busy    = s_busy;
        m1_ack     = w_done;
        err        = w_timeout;
      end
      default: begin
        // IDLE (and reset): defaults above. Nothing is forwarded, and a
        // stray s_ack is not passed to any master.
      end
    endcase
  end

  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios for the two-master round-robin arbiter, instantiated
// with TIMEOUT = 4. A behavioural model of who owns the bus is checked
// against every DUT output on every falling clock edge. Hand-computed
// literal expectations in each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
  logic [3:0]  m0_be, m1_be;
  logic        m0_wr_en, m0_rd_en, m1_wr_en, m1_rd_en;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        m0_busy, m0_ack, m1_busy, m1_ack;
  logic [31:0] s_addr, s_wr_data, s_rd_data;
  logic [3:0]  s_be;
  logic        s_wr_en, s_rd_en, s_busy, s_ack;
  logic        err;
  logic [1:0]  o_dbg_state;
  logic        o_dbg_last_grant;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m0_addr          (m0_addr),
    .m0_be            (m0_be),
    .m0_wr_en         (m0_wr_en),
    .m0_rd_en         (m0_rd_en),
    .m0_wr_data       (m0_wr_data),
    .m0_rd_data       (m0_rd_data),
    .m0_busy          (m0_busy),
    .m0_ack           (m0_ack),
    .m1_addr          (m1_addr),
    .m1_be            (m1_be),
    .m1_wr_en         (m1_wr_en),
    .m1_rd_en         (m1_rd_en),
    .m1_wr_data       (m1_wr_data),
    .m1_rd_data       (m1_rd_data),
    .m1_busy          (m1_busy),
    .m1_ack           (m1_ack),
    .s_addr           (s_addr),
    .s_be             (s_be),
    .s_wr_en          (s_wr_en),
    .s_wr_data        (s_wr_data),
    .s_rd_en          (s_rd_en),
    .s_rd_data        (s_rd_data),
    .s_busy           (s_busy),
    .s_ack            (s_ack),
    .err              (err),
    .o_dbg_state      (o_dbg_state),
    .o_dbg_last_grant (o_dbg_last_grant)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 = nobody, 0/1 = master being served
  // last: most recently served master
  // wait: grant cycles so far without a slave ack
  int md_owner = -1;
  int md_last  = 1;
  int md_wait  = 0;

  function automatic bit wants(input int m);
    return (m == 0) ? (m0_wr_en | m0_rd_en) : (m1_wr_en | m1_rd_en);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_owner <= -1;
      md_last  <= 1;
      md_wait  <= 0;
    end else if (md_owner < 0) begin
      if (wants(0) && wants(1)) begin
        md_owner <= 1 - md_last;
        md_last  <= 1 - md_last;
        md_wait  <= 0;
      end else if (wants(0) || wants(1)) begin
        md_owner <= wants(0) ? 0 : 1;
        md_last  <= wants(0) ? 0 : 1;
        md_wait  <= 0;
      end
    end else begin
      // The transfer ends on an ack, or after TO grant cycles without one.
      if (s_ack || (md_wait == TO - 1)) begin
        if (wants(1 - md_owner)) begin
          md_owner <= 1 - md_owner;
          md_last  <= 1 - md_owner;
          md_wait  <= 0;
        end else begin
          md_owner <= -1;
        end
      end else if (md_wait < 255) begin
        md_wait <= md_wait + 1;
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [1:0] exp_q[$];    // expected grant order (hand-written)
  logic [1:0] grant_q[$];  // observed grant order
  logic [1:0] prev_dbg = 2'd0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  int err_cnt  = 0;

  always @(negedge clock) begin : cmp
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    logic [3:0]  e_be;
    logic        e_wr, e_rd, e_busy0, e_busy1, e_ack0, e_ack1, e_err, to_c;
    logic [1:0]  e_dbg;
    e_addr = 0; e_wdata = 0; e_be = 0; e_wr = 0; e_rd = 0;
    e_rd0 = 0; e_rd1 = 0; e_busy0 = 1; e_busy1 = 1; e_ack0 = 0; e_ack1 = 0;
    e_err = 0; e_dbg = 2'd0; to_c = 0;
    if (md_owner >= 0) begin
      to_c    = !s_ack && (md_wait == TO - 1);
      e_addr  = (md_owner == 0) ? m0_addr : m1_addr;
      e_be    = (md_owner == 0) ? m0_be : m1_be;
      e_wdata = (md_owner == 0) ? m0_wr_data : m1_wr_data;
      e_wr    = to_c ? 1'b0 : ((md_owner == 0) ? m0_wr_en : m1_wr_en);
      e_rd    = to_c ? 1'b0 : ((md_owner == 0) ? m0_rd_en : m1_rd_en);
      e_err   = to_c;
      e_dbg   = (md_owner == 0) ? 2'd1 : 2'd2;
      if (md_owner == 0) begin
        e_rd0 = to_c ? 32'd0 : s_rd_data; e_busy0 = s_busy; e_ack0 = s_ack | to_c;
      end else begin
        e_rd1 = to_c ? 32'd0 : s_rd_data; e_busy1 = s_busy; e_ack1 = s_ack | to_c;
      end
    end
    chk("s_addr", s_addr, e_addr);
    chk("s_be", 32'(s_be), 32'(e_be));
    chk("s_wr_data", s_wr_data, e_wdata);
    chk("s_wr_en", 32'(s_wr_en), 32'(e_wr));
    chk("s_rd_en", 32'(s_rd_en), 32'(e_rd));
    chk("m0_rd_data", m0_rd_data, e_rd0);
    chk("m1_rd_data", m1_rd_data, e_rd1);
    chk("m0_busy", 32'(m0_busy), 32'(e_busy0));
    chk("m1_busy", 32'(m1_busy), 32'(e_busy1));
    chk("m0_ack", 32'(m0_ack), 32'(e_ack0));
    chk("m1_ack", 32'(m1_ack), 32'(e_ack1));
    chk("err", 32'(err), 32'(e_err));
    chk("state", 32'(o_dbg_state), 32'(e_dbg));
    chk("last_grant", 32'(o_dbg_last_grant), 32'(md_last));

    if (o_dbg_state != prev_dbg && o_dbg_state != 2'd0) grant_q.push_back(o_dbg_state - 2'd1);
    prev_dbg <= o_dbg_state;
    ack_cnt0 <= ack_cnt0 + int'(m0_ack);
    ack_cnt1 <= ack_cnt1 + int'(m1_ack);
    err_cnt  <= err_cnt + int'(err);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock); #1;
  endtask

  task automatic clear_inputs();
    m0_addr = 0; m0_be = 0; m0_wr_en = 0; m0_rd_en = 0; m0_wr_data = 0;
    m1_addr = 0; m1_be = 0; m1_wr_en = 0; m1_rd_en = 0; m1_wr_data = 0;
    s_rd_data = 0; s_busy = 0; s_ack = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int snap0, snap1, snap_e;
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    sample();
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    chk("rst_last_grant", 32'(o_dbg_last_grant), 32'd1);
    chk("rst_m0_busy", 32'(m0_busy), 32'd1);
    chk("rst_s_rd_en", 32'(s_rd_en), 32'd0);
    reset_n = 1'b1;

    // Simultaneous reads. m0 wins, then m1 is granted directly.
    step(); m0_rd_en = 1; m0_addr = 32'h100; m1_rd_en = 1; m1_addr = 32'h200;
    sample(); chk("s1_idle_state", 32'(o_dbg_state), 32'd0);
    chk("s1_idle_s_rd_en", 32'(s_rd_en), 32'd0);
    step(); s_ack = 1; s_rd_data = 32'hAAAA5555;
    sample(); chk("s1_g0_saddr", s_addr, 32'h100);
    chk("s1_m0_ack", 32'(m0_ack), 32'd1);
    chk("s1_m0_rd", m0_rd_data, 32'hAAAA5555);
    chk("s1_m1_ack", 32'(m1_ack), 32'd0);
    chk("s1_m1_rd", m1_rd_data, 32'd0);
    step(); m0_rd_en = 0; s_rd_data = 32'h0BADF00D;
    sample(); chk("s1_g1_state", 32'(o_dbg_state), 32'd2);
    chk("s1_g1_saddr", s_addr, 32'h200);
    chk("s1_m1_rd", m1_rd_data, 32'h0BADF00D);
    step(); clear_inputs();
    sample(); chk("s1_end_state", 32'(o_dbg_state), 32'd0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);

    // m1 back-to-back, m0 requests once. Grants go 1,0,1.
    step(); m1_wr_en = 1; m1_addr = 32'h300; m1_be = 4'hF; m1_wr_data = 32'hCAFE0001;
    sample();
    step(); m0_rd_en = 1; m0_addr = 32'h104; s_ack = 1;
    sample(); chk("s2_first", 32'(o_dbg_state), 32'd2);
    step(); s_rd_data = 32'h11112222;
    sample(); chk("s2_second", 32'(o_dbg_state), 32'd1);
    chk("s2_m0_rd", m0_rd_data, 32'h11112222);
    chk("s2_m1_busy", 32'(m1_busy), 32'd1);
    step(); m0_rd_en = 0;
    sample(); chk("s2_third", 32'(o_dbg_state), 32'd2);
    chk("s2_s_wr_en", 32'(s_wr_en), 32'd1);
    step(); clear_inputs();
    sample(); chk("s2_end_state", 32'(o_dbg_state), 32'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd1);

    // m1 write. The slave is busy for 3 cycles, then acks in the last
    // allowed cycle, so the ack wins over the timeout.
    step(); m1_wr_en = 1; m1_addr = 32'h40; m1_be = 4'h3; m1_wr_data = 32'h12345678;
    snap1 = ack_cnt1;
    sample();
    step(); s_busy = 1;
    sample(); chk("s3_saddr", s_addr, 32'h40);
    chk("s3_sbe", 32'(s_be), 32'h3);
    chk("s3_swr", 32'(s_wr_en), 32'd1);
    chk("s3_swdata", s_wr_data, 32'h12345678);
    chk("s3_srd", 32'(s_rd_en), 32'd0);
    chk("s3_m1_ack", 32'(m1_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("s3_m1_busy", 32'(m1_busy), 32'd1);
      chk("s3_m0_busy", 32'(m0_busy), 32'd1);
      if (i < 2) begin step(); sample(); end
    end
    step(); s_busy = 0; s_ack = 1;
    sample(); chk("s3_ack", 32'(m1_ack), 32'd1);
    chk("s3_err", 32'(err), 32'd0);
    chk("s3_m1_busy_low", 32'(m1_busy), 32'd0);
    chk("s3_m0_busy", 32'(m0_busy), 32'd1);
    chk("s3_swr_last", 32'(s_wr_en), 32'd1);
    step(); clear_inputs();
    sample(); chk("s3_end_state", 32'(o_dbg_state), 32'd0);
    chk("s3_ack_count", 32'(ack_cnt1 - snap1), 32'd1);
    exp_q.push_back(2'd1);

    // The slave never acks. Timeout on the 4th grant cycle.
    step(); m0_rd_en = 1; m0_addr = 32'h500;
    snap_e = err_cnt;
    sample();
    step(); s_rd_data = 32'hDEADBEEF;
    sample(); chk("s4_c1_ack", 32'(m0_ack), 32'd0);
    chk("s4_c1_err", 32'(err), 32'd0);
    chk("s4_c1_rd_en", 32'(s_rd_en), 32'd1);
    chk("s4_c1_rd", m0_rd_data, 32'hDEADBEEF);
    step(); sample(); chk("s4_c2_err", 32'(err), 32'd0);
    step(); sample(); chk("s4_c3_err", 32'(err), 32'd0);
    step(); sample();
    chk("s4_to_ack", 32'(m0_ack), 32'd1);
    chk("s4_to_err", 32'(err), 32'd1);
    chk("s4_to_rd", m0_rd_data, 32'd0);
    chk("s4_to_rd_en", 32'(s_rd_en), 32'd0);
    chk("s4_to_saddr", s_addr, 32'h500);
    step(); clear_inputs();
    sample(); chk("s4_end_state", 32'(o_dbg_state), 32'd0);
    chk("s4_end_err", 32'(err), 32'd0);
    chk("s4_err_count", 32'(err_cnt - snap_e), 32'd1);
    exp_q.push_back(2'd0);

    // Reset pulse in the middle of GRANT1.
    step(); m1_rd_en = 1; m1_addr = 32'h600;
    snap0 = ack_cnt0; snap1 = ack_cnt1;
    sample();
    step(); s_busy = 1; s_rd_data = 32'h77;
    sample(); chk("s5_g1_state", 32'(o_dbg_state), 32'd2);
    chk("s5_g1_rd", m1_rd_data, 32'h77);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_state", 32'(o_dbg_state), 32'd0);
    chk("s5_rst_srd", 32'(s_rd_en), 32'd0);
    chk("s5_rst_saddr", s_addr, 32'd0);
    chk("s5_rst_m1_busy", 32'(m1_busy), 32'd1);
    chk("s5_rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("s5_rst_m1_rd", m1_rd_data, 32'd0);
    chk("s5_rst_m0_busy", 32'(m0_busy), 32'd1);
    chk("s5_rst_err", 32'(err), 32'd0);
    chk("s5_rst_last", 32'(o_dbg_last_grant), 32'd1);
    m1_rd_en = 0; s_ack = 1;
    step(); sample();
    chk("s5_rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("s5_rst_m1_ack2", 32'(m1_ack), 32'd0);
    chk("s5_ack_count0", 32'(ack_cnt0 - snap0), 32'd0);
    chk("s5_ack_count1", 32'(ack_cnt1 - snap1), 32'd0);
    reset_n = 1'b1;
    s_ack = 0; s_busy = 0;
    step(); m0_rd_en = 1; m0_addr = 32'h700; m1_rd_en = 1; m1_addr = 32'h800;
    sample(); chk("s5_idle_state", 32'(o_dbg_state), 32'd0);
    step(); s_ack = 1; s_rd_data = 32'h1;
    sample(); chk("s5_m0_wins", 32'(o_dbg_state), 32'd1);
    chk("s5_saddr0", s_addr, 32'h700);
    step(); m0_rd_en = 0;
    sample(); chk("s5_then_m1", 32'(o_dbg_state), 32'd2);
    chk("s5_saddr1", s_addr, 32'h800);
    step(); clear_inputs();
    sample(); chk("s5_end_state", 32'(o_dbg_state), 32'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd1);

    // A spurious slave ack while IDLE is ignored.
    step(); s_ack = 1; s_rd_data = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("s6_m0_ack", 32'(m0_ack), 32'd0);
      chk("s6_m1_ack", 32'(m1_ack), 32'd0);
      chk("s6_m0_rd", m0_rd_data, 32'd0);
      chk("s6_state", 32'(o_dbg_state), 32'd0);
      step();
    end
    clear_inputs();
    sample();

    // Grant order over the whole run.
    chk("grant_count", 32'(grant_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < grant_q.size()) chk("grant_order", 32'(grant_q[i]), 32'(exp_q[i]));
      else chk("grant_missing", 32'hFFFFFFFF, 32'(exp_q[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of GRANT cycles without s_ack before the arbiter aborts the transfer; legal range 2..255.
REQ-002 clock  in  1  single clock for the block; every register updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 mN_addr  in  32  address from master N (N=0,1; master 0 = instruction fetch, master 1 = load/store).
REQ-005 mN_be  in  4  write byte enables from master N.
REQ-006 mN_wr_en, mN_rd_en  in  1  write and read enables from master N; request_N = mN_wr_en | mN_rd_en.
REQ-007 mN_wr_data  in  32  write data from master N.
REQ-008 mN_rd_data  out  32  read data returned to master N.
REQ-009 mN_busy, mN_ack  out  1  busy and transfer-acknowledge returned to master N.
REQ-010 s_addr, s_be, s_wr_en, s_wr_data, s_rd_en  out  32/4/1/32/1  request fields driven to the shared slave.
REQ-011 s_rd_data, s_busy, s_ack  in  32/1/1  response fields from the shared slave.
REQ-012 err  out  1  one-cycle pulse when a transfer is aborted on timeout.

Function
REQ-013 FSM states: IDLE, GRANT0, GRANT1; the state is held in a register.
REQ-014 last_grant register (1 bit) records the master most recently granted.
REQ-015 IDLE, exactly one request present: next state is GRANT of the requesting master.
REQ-016 IDLE, both masters requesting: next state is GRANT of the master != last_grant (round-robin).
REQ-017 IDLE, no request: state stays IDLE.
REQ-018 Arbitration latency is exactly one cycle from request to GRANT; nothing is forwarded to the slave while in IDLE.
REQ-019 In IDLE, all s_* request outputs are driven to 0.
REQ-020 In IDLE, mN_busy=1, mN_ack=0 and mN_rd_data=0 for both masters.
REQ-021 GRANTn: the granted master's request fields pass combinationally to the s_* outputs.
REQ-022 GRANTn: mn_rd_data=s_rd_data, mn_busy=s_busy and mn_ack=s_ack.
REQ-023 GRANTn: the non-granted master sees busy=1, ack=0 and rd_data=0.
REQ-024 The granted master holds its request fields stable until it sees ack; the arbiter does not register them.
REQ-025 Entering GRANTn sets last_grant=n.
REQ-026 GRANTn with s_ack=1: next state is GRANT of the other master if that master is requesting; otherwise IDLE.
REQ-027 A master therefore never receives two consecutive grants while the other master is waiting.
REQ-028 8-bit wait counter: cleared on every GRANT entry, incremented on each GRANT cycle with s_ack=0, saturates at 255.
REQ-029 GRANTn, counter = TIMEOUT-1 and s_ack=0: the arbiter drives mn_ack=1, mn_rd_data=0 and err=1 for that cycle.
REQ-030 In that timeout cycle, s_rd_en and s_wr_en are forced to 0 and the next-state rule of REQ-026 applies.
REQ-031 s_ack arriving in the same cycle as the timeout takes precedence: a normal ack, err=0.
REQ-032 s_ack while in IDLE is ignored and no master ack is generated.
REQ-033 A master dropping its request while in GRANT does not abort the grant; the grant ends only on ack or timeout.

Reset
REQ-034 reset_n=0 immediately forces: state=IDLE, last_grant=1, counter=0, err=0.
REQ-035 reset_n=0 drives all s_* request outputs to 0, mN_busy=1, mN_ack=0 and mN_rd_data=0.
REQ-036 Reset asserted during GRANT abandons the transfer; no ack is generated to either master.
REQ-037 Release of reset is synchronised by the integrator; the first arbitration decision happens on the first rising edge after release.

Verification
REQ-038 After reset, m0 and m1 read simultaneously (m0_addr=0x100, m1_addr=0x200); slave acks after 1 cycle with 0xAAAA5555 -> GRANT0 first, m0 receives 0xAAAA5555, then GRANT1 directly with s_addr=0x200.
REQ-039 m1 issues continuous back-to-back requests while m0 requests once -> grants alternate 1,0,1; m0 waits at most one transfer.
REQ-040 m1 writes addr 0x40, be=0x3, data 0x12345678; slave busy for 3 cycles then acks -> s_* fields match exactly, m1_busy mirrors s_busy, single m1_ack, m0_busy=1 throughout.
REQ-041 TIMEOUT=4, slave never acks -> m0_ack=1 and err=1 on the 4th GRANT cycle, m0_rd_data=0, s_rd_en=0 in that cycle, then state returns to IDLE.
REQ-042 reset_n pulsed low during GRANT1 -> all outputs reach reset values with no clock edge, no ack is generated; after release m0 wins a simultaneous request.
REQ-043 Spurious s_ack=1 while IDLE -> mN_ack stays 0 and state stays IDLE.
